// File: rtl/sysbus_pkg.sv
// Shared types and constants for the SysBus memory-side bridge.
package sysbus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } bridge_state_t;

    localparam int          TIMEOUT_DEFAULT = 15;
    localparam logic [15:0] BUS_ERR_DATA    = 16'hFFFF;

endpackage

// File: rtl/sysbus_addr_latch.sv
// Address and write-data holding registers for the SysBus bridge, each with its own load enable.
module sysbus_addr_latch #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          Clock,
    input  logic          nReset,
    input  logic          loadAddr,
    input  logic          loadWData,
    input  logic [DW-1:0] busIn,
    output logic [AW-1:0] addrReg,
    output logic [DW-1:0] wDataReg
);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            addrReg  <= '0;
            wDataReg <= '0;
        end else begin
            if (loadAddr)  addrReg  <= busIn[AW-1:0];
            if (loadWData) wDataReg <= busIn;
        end
    end

endmodule

// File: rtl/sysbus_bridge.sv
// SysBus-to-memory request/acknowledge bridge with Ready handshake toward the core.
// Optional MemAck timeout with BusErr is enabled by defining SYSBUS_BRIDGE_TIMEOUT_EN.
module sysbus_bridge
    import sysbus_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16
`ifdef SYSBUS_BRIDGE_TIMEOUT_EN
    ,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
`endif
) (
    input  logic          Clock,
    input  logic          nReset,
    input  logic [DW-1:0] SysBusIn,
    input  logic          ALE,
    input  logic          nME,
    input  logic          nOE,
    input  logic          nWE,
    input  logic          ENB,
    output logic [DW-1:0] SysBusOut,
    output logic          SysBusOe,
    output logic          Ready,
    output logic          BusErr,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    output logic          MemReq,
    output logic          MemWr,
    input  logic          MemAck,
    input  logic [DW-1:0] MemRData
);

    bridge_state_t state;
    bridge_state_t stateNext;

    logic [AW-1:0] addrReg;
    logic [DW-1:0] wDataReg;
    logic [DW-1:0] rDataReg;
    logic          lastRead;
    logic          busy;
    logic          loadAddr;
    logic          loadWData;
    logic          startTxn;
    logic          ackHit;
    logic          toHit;

`ifdef SYSBUS_BRIDGE_TIMEOUT_EN
    logic [3:0] waitCnt;
    logic       busErrReg;
`endif

    sysbus_addr_latch #(
        .AW(AW),
        .DW(DW)
    ) uLatch (
        .Clock    (Clock),
        .nReset   (nReset),
        .loadAddr (loadAddr),
        .loadWData(loadWData),
        .busIn    (SysBusIn),
        .addrReg  (addrReg),
        .wDataReg (wDataReg)
    );

    always_comb begin
        stateNext = state;
        loadAddr  = 1'b0;
        loadWData = 1'b0;
        startTxn  = 1'b0;
        ackHit    = 1'b0;
        toHit     = 1'b0;
        case (state)
            IDLE: begin
                loadAddr = ALE;
                // nWE wins when both strobes are low
                if (!nME && !nWE) begin
                    stateNext = WRITE;
                    loadWData = 1'b1;
                    startTxn  = 1'b1;
                end else if (!nME && !nOE) begin
                    stateNext = READ;
                    startTxn  = 1'b1;
                end
            end
            READ, WRITE: begin
                if (MemAck) begin
                    stateNext = DONE;
                    ackHit    = 1'b1;
                end
`ifdef SYSBUS_BRIDGE_TIMEOUT_EN
                else if (waitCnt == 4'(TIMEOUT - 1)) begin
                    stateNext = DONE;
                    toHit     = 1'b1;
                end
`endif
            end
            DONE: begin
                if (nME) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            rDataReg <= '0;
            lastRead <= 1'b0;
        end else begin
            state <= stateNext;
            if (startTxn) lastRead <= (stateNext == READ);
            if (ackHit && state == READ) rDataReg <= MemRData;
            else if (toHit) rDataReg <= DW'(BUS_ERR_DATA);
        end
    end

`ifdef SYSBUS_BRIDGE_TIMEOUT_EN
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            waitCnt   <= '0;
            busErrReg <= 1'b0;
        end else begin
            if (startTxn) waitCnt <= '0;
            else if (busy && !MemAck) waitCnt <= waitCnt + 4'd1;
            // error flag persists through IDLE until the next transaction starts
            if (startTxn) busErrReg <= 1'b0;
            else if (toHit) busErrReg <= 1'b1;
        end
    end

    assign BusErr = busErrReg;
`else
    assign BusErr = 1'b0;
`endif

    // Outputs decode from state only; SysBusOe is the single ENB-gated exception
    assign busy      = (state == READ) || (state == WRITE);
    assign MemReq    = busy;
    assign MemWr     = (state == WRITE);
    assign MemAddr   = busy ? addrReg : '0;
    assign MemWData  = busy ? wDataReg : '0;
    assign Ready     = (state == DONE);
    assign SysBusOut = (state == DONE) ? rDataReg : '0;
    assign SysBusOe  = ENB && (state == DONE) && lastRead;

endmodule

// File: tb/tb_sysbus_bridge.sv
// Randomized self-checking bench for sysbus_bridge against a transaction-level memory model.
module tb_sysbus_bridge;

    logic        Clock = 1'b0;
    logic        nReset;
    logic [15:0] SysBusIn;
    logic        ALE, nME, nOE, nWE, ENB;
    logic [15:0] SysBusOut;
    logic        SysBusOe, Ready, BusErr;
    logic [15:0] MemAddr, MemWData;
    logic        MemReq, MemWr, MemAck;
    logic [15:0] MemRData;

    int assertCount = 0;
    int failCount   = 0;

    logic [15:0] memModel [logic [15:0]];
    logic [15:0] latchedAddr = 16'h0000;

    always #5 Clock = ~Clock;

    sysbus_bridge dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .SysBusIn (SysBusIn),
        .ALE      (ALE),
        .nME      (nME),
        .nOE      (nOE),
        .nWE      (nWE),
        .ENB      (ENB),
        .SysBusOut(SysBusOut),
        .SysBusOe (SysBusOe),
        .Ready    (Ready),
        .BusErr   (BusErr),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .MemReq   (MemReq),
        .MemWr    (MemWr),
        .MemAck   (MemAck),
        .MemRData (MemRData)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [15:0] memRead(input logic [15:0] a);
        if (memModel.exists(a)) return memModel[a];
        return a ^ 16'hA5C3;
    endfunction

    // One complete core transaction; the bench plays the memory and checks cycle by cycle
    task automatic runTxn(input bit isWrite, input bit useAle, input logic [15:0] addr,
                          input logic [15:0] wdata, input int waits, input bit bothStrobes);
        logic [15:0] expAddr;
        logic [15:0] expRData;
        if (useAle) begin
            ALE      = 1'b1;
            SysBusIn = addr;
            MemAck   = 1'($urandom);
            tick;
            ALE         = 1'b0;
            latchedAddr = addr;
            checkEq("idleReq", 32'(MemReq), 32'(0));
            checkEq("idleReady", 32'(Ready), 32'(0));
        end
        expAddr  = latchedAddr;
        MemAck   = 1'b0;
        nME      = 1'b0;
        nWE      = !isWrite;
        nOE      = isWrite && !bothStrobes;
        SysBusIn = isWrite ? wdata : 16'($urandom);
        tick;
        checkEq("reqRise", 32'(MemReq), 32'(1));
        checkEq("addr", 32'(MemAddr), 32'(expAddr));
        checkEq("memWr", 32'(MemWr), 32'(isWrite));
        checkEq("readyBusy", 32'(Ready), 32'(0));
        checkEq("busErrClr", 32'(BusErr), 32'(0));
        if (isWrite) checkEq("wdata", 32'(MemWData), 32'(wdata));
        nOE = 1'b1;
        nWE = 1'b1;
        for (int i = 0; i < waits; i++) begin
            ALE      = (i == 0) ? 1'b1 : 1'($urandom);
            SysBusIn = (i == 0) ? 16'hFFFF : 16'($urandom);
            nOE      = 1'($urandom);
            nWE      = 1'($urandom);
            tick;
            checkEq("holdReq", 32'(MemReq), 32'(1));
            checkEq("holdAddr", 32'(MemAddr), 32'(expAddr));
            checkEq("holdWr", 32'(MemWr), 32'(isWrite));
        end
        ALE      = 1'b0;
        MemAck   = 1'b1;
        MemRData = memRead(MemAddr);
        tick;
        MemAck   = 1'b0;
        MemRData = 16'($urandom);
        checkEq("ready", 32'(Ready), 32'(1));
        checkEq("reqDrop", 32'(MemReq), 32'(0));
        checkEq("busErr", 32'(BusErr), 32'(0));
        expRData = memRead(expAddr);
        if (isWrite) memModel[expAddr] = wdata;
        ENB = 1'b1;
        #1;
        checkEq("oe", 32'(SysBusOe), 32'(!isWrite));
        if (!isWrite) checkEq("rdata", 32'(SysBusOut), 32'(expRData));
        ENB = 1'b0;
        #1;
        checkEq("oeOff", 32'(SysBusOe), 32'(0));
        if (1'($urandom)) begin
            tick;
            checkEq("doneHold", 32'(Ready), 32'(1));
        end
        nME = 1'b1;
        nOE = 1'b1;
        nWE = 1'b1;
        tick;
        checkEq("backIdle", 32'(Ready), 32'(0));
        checkEq("idleNoReq", 32'(MemReq), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nReset   = 1'b0;
        SysBusIn = 16'h0000;
        ALE      = 1'b0;
        nME      = 1'b1;
        nOE      = 1'b1;
        nWE      = 1'b1;
        ENB      = 1'b1;
        MemAck   = 1'b0;
        MemRData = 16'h0000;
        repeat (3) @(posedge Clock);
        #1;
        checkEq("rstReq", 32'(MemReq), 32'(0));
        checkEq("rstWr", 32'(MemWr), 32'(0));
        checkEq("rstReady", 32'(Ready), 32'(0));
        checkEq("rstBusErr", 32'(BusErr), 32'(0));
        checkEq("rstOe", 32'(SysBusOe), 32'(0));
        checkEq("rstOut", 32'(SysBusOut), 32'(0));
        checkEq("rstAddr", 32'(MemAddr), 32'(0));
        checkEq("rstWData", 32'(MemWData), 32'(0));
        ENB    = 1'b0;
        nReset = 1'b1;
        tick;

        // Directed cases from the block's usage scenarios
        memModel[16'h0040] = 16'hBEEF;
        runTxn(1'b0, 1'b1, 16'h0040, 16'h0000, 0, 1'b0);
        runTxn(1'b1, 1'b1, 16'h0102, 16'h1234, 3, 1'b0);
        runTxn(1'b0, 1'b0, 16'h0000, 16'h0000, 2, 1'b0);
        runTxn(1'b1, 1'b1, 16'h0200, 16'h5555, 1, 1'b1);
        runTxn(1'b0, 1'b1, 16'h0200, 16'h0000, 1, 1'b0);

        // Reset in the middle of a read
        ALE      = 1'b1;
        SysBusIn = 16'h0333;
        tick;
        ALE = 1'b0;
        nME = 1'b0;
        nOE = 1'b0;
        tick;
        checkEq("midReq", 32'(MemReq), 32'(1));
        tick;
        ENB    = 1'b1;
        nReset = 1'b0;
        #1;
        checkEq("asyncReq", 32'(MemReq), 32'(0));
        checkEq("asyncAddr", 32'(MemAddr), 32'(0));
        checkEq("asyncReady", 32'(Ready), 32'(0));
        checkEq("asyncOe", 32'(SysBusOe), 32'(0));
        checkEq("asyncOut", 32'(SysBusOut), 32'(0));
        nME    = 1'b1;
        nOE    = 1'b1;
        ENB    = 1'b0;
        nReset = 1'b1;
        latchedAddr = 16'h0000;
        tick;
        checkEq("postRstReq", 32'(MemReq), 32'(0));
        checkEq("postRstReady", 32'(Ready), 32'(0));
        runTxn(1'b1, 1'b0, 16'h0000, 16'h7E57, 0, 1'b0);

        // Randomized traffic over a small address pool so reads revisit writes
        for (int n = 0; n < 40; n++) begin
            runTxn(1'($urandom), ($urandom_range(0, 3) != 0),
                   16'($urandom_range(0, 7) << 4), 16'($urandom),
                   int'($urandom_range(0, 4)), 1'($urandom));
        end

        // MemAck never arrives
        ALE      = 1'b1;
        SysBusIn = 16'h0777;
        tick;
        ALE = 1'b0;
        nME = 1'b0;
        nOE = 1'b0;
        tick;
        nOE = 1'b1;
        checkEq("toReqRise", 32'(MemReq), 32'(1));
`ifdef SYSBUS_BRIDGE_TIMEOUT_EN
        begin
            int cycles;
            cycles = 0;
            while (MemReq && cycles < 40) begin
                tick;
                cycles++;
            end
            checkEq("toCycles", 32'(cycles), 32'(15));
            checkEq("toReady", 32'(Ready), 32'(1));
            checkEq("toBusErr", 32'(BusErr), 32'(1));
            ENB = 1'b1;
            #1;
            checkEq("toOut", 32'(SysBusOut), 32'hFFFF);
            checkEq("toOe", 32'(SysBusOe), 32'(1));
            ENB = 1'b0;
            nME = 1'b1;
            tick;
            checkEq("toErrHeld", 32'(BusErr), 32'(1));
            runTxn(1'b0, 1'b1, 16'h0010, 16'h0000, 1, 1'b0);
        end
`else
        repeat (100) tick;
        checkEq("noToReq", 32'(MemReq), 32'(1));
        checkEq("noToReady", 32'(Ready), 32'(0));
        checkEq("noToBusErr", 32'(BusErr), 32'(0));
        MemAck   = 1'b1;
        MemRData = 16'h1111;
        tick;
        MemAck = 1'b0;
        checkEq("lateAckReady", 32'(Ready), 32'(1));
        ENB = 1'b1;
        #1;
        checkEq("lateAckData", 32'(SysBusOut), 32'h1111);
        ENB = 1'b0;
        nME = 1'b1;
        tick;
        checkEq("lateAckIdle", 32'(Ready), 32'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
